// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundle of the fetch-side push port, the decode-side pop port and the
//   status outputs of fetch_queue. Signal suffixes are from the point of view
//   of the queue (_i = into the queue, _o = out of the queue).
//
//   Modports:
//     slave  - the queue itself
//     master - the fetch/decode side (or a testbench) driving the queue
//
//   Signals:
//     flush_i        redirect; empties the queue
//     push_valid_i   slot valid bits (00, 01, 11)
//     push_instr0_i  instruction at push_pc_i
//     push_instr1_i  instruction at push_pc_i+4
//     push_pc_i      PC of slot 0
//     pop_cnt_i      entries consumed by decode this cycle (0..2)
//     ready_o        at least two free entries (fetch enable)
//     out_valid_o    head / head+1 valid (00, 01, 11)
//     out_instr0_o   head instruction
//     out_instr1_o   head+1 instruction
//     out_pc0_o      head PC
//     out_pc1_o      head+1 PC
//     count_o        occupancy
//     overflow_o     pulse after a push was dropped
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic [1:0]       push_valid_i;
    logic [WIDTH-1:0] push_instr0_i;
    logic [WIDTH-1:0] push_instr1_i;
    logic [WIDTH-1:0] push_pc_i;
    logic [1:0]       pop_cnt_i;
    logic             ready_o;
    logic [1:0]       out_valid_o;
    logic [WIDTH-1:0] out_instr0_o;
    logic [WIDTH-1:0] out_instr1_o;
    logic [WIDTH-1:0] out_pc0_o;
    logic [WIDTH-1:0] out_pc1_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;

    modport slave (
        input  flush_i, push_valid_i, push_instr0_i, push_instr1_i, push_pc_i,
               pop_cnt_i,
        output ready_o, out_valid_o, out_instr0_o, out_instr1_o, out_pc0_o,
               out_pc1_o, count_o, overflow_o
    );

    modport master (
        output flush_i, push_valid_i, push_instr0_i, push_instr1_i, push_pc_i,
               pop_cnt_i,
        input  ready_o, out_valid_o, out_instr0_o, out_instr1_o, out_pc0_o,
               out_pc1_o, count_o, overflow_o
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Dual-slot instruction fetch queue between a two-wide fetch stage and a
//   dual-issue decoder. Circular buffer of DEPTH {instr, pc} entries with
//   head/tail pointers and a separate occupancy counter. Up to two entries are
//   pushed and up to two popped per cycle; flush empties the queue.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset (control state only)
//     bus  - fetch_queue_if.slave: push port, pop port, status (see interface)
//
//   Optional feature:
//     FETCH_QUEUE_BYPASS_EN - when defined, an empty queue forwards the push
//     slots to the outputs in the same cycle; slots consumed by decode that
//     cycle are never written, the rest are enqueued.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] pc_q    [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0]    push_n, pop_req, avail, pop_eff, enq_n, head_adv;
    logic             ready, bypass, skip0, wr0_en, wr1_en;
    logic [WIDTH-1:0] pc1_in, wr0_instr, wr0_pc;
    logic [PW-1:0]    head1, tail1;

    always_comb begin
        push_n  = CW'(bus.push_valid_i[0]) + CW'(bus.push_valid_i[1]);
        pop_req = CW'(bus.pop_cnt_i);
        ready   = (count_q <= CW'(DEPTH - 2));
        pc1_in  = bus.push_pc_i + WIDTH'(4);
        bypass  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass  = (count_q == '0) && !bus.flush_i;
`endif
        // In bypass the decoder pops straight from the push slots.
        avail   = bypass ? push_n : count_q;
        pop_eff = (pop_req < avail) ? pop_req : avail;

        if (bus.flush_i || !ready) begin
            enq_n = '0;
        end else if (bypass) begin
            enq_n = push_n - pop_eff;
        end else begin
            enq_n = push_n;
        end
        head_adv = bypass ? '0 : pop_eff;

        // When bypass consumed slot 0, the surviving slot 1 lands at tail.
        skip0     = bypass && (pop_eff != '0);
        wr0_en    = (enq_n >= CW'(1));
        wr1_en    = (enq_n >= CW'(2));
        wr0_instr = skip0 ? bus.push_instr1_i : bus.push_instr0_i;
        wr0_pc    = skip0 ? pc1_in : bus.push_pc_i;

        count_d = count_q + enq_n - head_adv;
        tail_d  = tail_q + enq_n[PW-1:0];
        head_d  = head_q + head_adv[PW-1:0];
        ovf_d   = !ready && (push_n != '0);

        head1 = head_q + PW'(1);
        tail1 = tail_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            instr_q[tail_q] <= wr0_instr;
            pc_q[tail_q]    <= wr0_pc;
        end
        if (wr1_en) begin
            instr_q[tail1] <= bus.push_instr1_i;
            pc_q[tail1]    <= pc1_in;
        end
    end

    always_comb begin
        bus.out_valid_o  = {count_q >= CW'(2), count_q >= CW'(1)};
        bus.out_instr0_o = instr_q[head_q];
        bus.out_instr1_o = instr_q[head1];
        bus.out_pc0_o    = pc_q[head_q];
        bus.out_pc1_o    = pc_q[head1];
        if (bypass) begin
            bus.out_valid_o  = bus.push_valid_i;
            bus.out_instr0_o = bus.push_instr0_i;
            bus.out_instr1_o = bus.push_instr1_i;
            bus.out_pc0_o    = bus.push_pc_i;
            bus.out_pc1_o    = pc1_in;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue (default build, no bypass). A queue of
//   {instr, pc} records models the FIFO; directed scenarios are followed by a
//   randomized phase with occasional flushes and resets.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    bit   m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        check("count", 64'(bus.count_o), 64'(sz));
        check("ready", 64'(bus.ready_o), 64'((DEPTH - sz) >= 2));
        check("overflow", 64'(bus.overflow_o), 64'(m_ovf));
        check("valid", 64'(bus.out_valid_o), (sz >= 2) ? 64'd3 : (sz == 1) ? 64'd1 : 64'd0);
        if (sz >= 1) begin
            check("pc0", 64'(bus.out_pc0_o), 64'(mq[0].pc));
            check("instr0", 64'(bus.out_instr0_o), 64'(mq[0].instr));
        end
        if (sz >= 2) begin
            check("pc1", 64'(bus.out_pc1_o), 64'(mq[1].pc));
            check("instr1", 64'(bus.out_instr1_o), 64'(mq[1].instr));
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare.
    task automatic step(input logic r, input logic f, input logic [1:0] pv,
                        input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] pop);
        int          sz_pre, pe, pn;
        bit          rdy_pre;
        logic [31:0] pc_plus4;
        ent_t        e;
        rst              = r;
        bus.flush_i      = f;
        bus.push_valid_i = pv;
        bus.push_pc_i    = pc;
        bus.push_instr0_i = i0;
        bus.push_instr1_i = i1;
        bus.pop_cnt_i    = pop;
        sz_pre  = mq.size();
        rdy_pre = (DEPTH - sz_pre) >= 2;
        @(posedge clk);
        #1;
        if (r || f) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pn = int'(pv[0]) + int'(pv[1]);
            pe = (int'(pop) > sz_pre) ? sz_pre : int'(pop);
            for (int k = 0; k < pe; k++) void'(mq.pop_front());
            if (rdy_pre) begin
                pc_plus4 = pc + 32'd4;
                if (pv[0]) begin e.instr = i0; e.pc = pc;       mq.push_back(e); end
                if (pv[1]) begin e.instr = i1; e.pc = pc_plus4; mq.push_back(e); end
            end
            m_ovf = !rdy_pre && (pn != 0);
        end
        check_outputs();
    endtask

    initial begin
        logic [31:0] pc;
        logic [1:0]  pv, pop;
        logic        f, r;
        int          sel;

        m_ovf = 1'b0;
        // Reset state
        step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
        step(1'b1, 1'b0, 2'b11, 32'h40, 32'h1, 32'h2, 2'd2);
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_ovf", 64'(bus.overflow_o), 64'd0);

        // First push visible next cycle
        step(1'b0, 1'b0, 2'b11, 32'h100, 32'hA, 32'hB, 2'd0);
        check("tp1_valid", 64'(bus.out_valid_o), 64'd3);
        check("tp1_pc0", 64'(bus.out_pc0_o), 64'h100);
        check("tp1_pc1", 64'(bus.out_pc1_o), 64'h104);
        check("tp1_instr1", 64'(bus.out_instr1_o), 64'hB);
        check("tp1_count", 64'(bus.count_o), 64'd2);

        // Fill from empty, then overflow
        step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
        pc = 32'h200;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 2'b11, pc, $urandom, $urandom, 2'd0);
            pc += 32'd8;
        end
        check("full_count", 64'(bus.count_o), 64'd8);
        check("full_ready", 64'(bus.ready_o), 64'd0);
        step(1'b0, 1'b0, 2'b11, pc, $urandom, $urandom, 2'd0);
        check("ovf_pulse", 64'(bus.overflow_o), 64'd1);
        check("ovf_count", 64'(bus.count_o), 64'd8);

        // Wrap-around: pop 2 while pushing 11; first push is dropped (full)
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 2'b11, pc, $urandom, $urandom, 2'd2);
            if (k > 1) pc += 32'd8;
            check("wrap_pc0", 64'(bus.out_pc0_o), 64'(32'h200 + 32'(8 * k)));
            check("wrap_count", 64'(bus.count_o), 64'd6);
        end

        // Pop clamp at count 1
        step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
        step(1'b0, 1'b0, 2'b01, 32'h300, 32'h33, 32'h0, 2'd0);
        check("one_count", 64'(bus.count_o), 64'd1);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2);
        check("clamp_count", 64'(bus.count_o), 64'd0);
        check("clamp_valid", 64'(bus.out_valid_o), 64'd0);

        // Flush beats push/pop at count 5
        step(1'b0, 1'b0, 2'b11, 32'h400, $urandom, $urandom, 2'd0);
        step(1'b0, 1'b0, 2'b11, 32'h408, $urandom, $urandom, 2'd0);
        step(1'b0, 1'b0, 2'b01, 32'h410, $urandom, $urandom, 2'd0);
        check("pre_flush_count", 64'(bus.count_o), 64'd5);
        step(1'b0, 1'b1, 2'b11, 32'h500, $urandom, $urandom, 2'd1);
        check("flush_count", 64'(bus.count_o), 64'd0);
        check("flush_valid", 64'(bus.out_valid_o), 64'd0);
        check("flush_ovf", 64'(bus.overflow_o), 64'd0);
        step(1'b0, 1'b0, 2'b11, 32'h600, $urandom, $urandom, 2'd0);
        check("post_flush_pc0", 64'(bus.out_pc0_o), 64'h600);

        // PC+4 wraps modulo 2^32
        step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
        step(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFC, $urandom, $urandom, 2'd0);
        check("pcwrap_pc1", 64'(bus.out_pc1_o), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 2));
            pv  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            pop = 2'($urandom_range(0, 2));
            f   = ($urandom_range(0, 29) == 0);
            r   = ($urandom_range(0, 199) == 0);
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(r, f, pv, pc, $urandom, $urandom, pop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
